gate_response_checker: RTL and testbench
========================================

// Module: gate_response_checker
// PURPOSE
//  Synthesizable self-checking driver/monitor for the basic two-input gate block.
//  On start, drives all four (a,b) combinations in order 00,01,10,11.
//  Waits a settle interval per vector, samples the four gate outputs and compares them to golden values.
//  Reports per-gate failures, a mismatch count and pass/done status. It is the response end of the exhaustive gate stimulus flow.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles a vector is held before sampling; legal range >= 1
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  one-cycle pulse; begins a run when in IDLE or DONE
//  dut_a      out  1  gate input a (registered), a = vec[1]
//  dut_b      out  1  gate input b (registered), b = vec[0]
//  dut_y      in   4  gate outputs: [0]=AND [1]=OR [2]=XOR [3]=NAND
//  busy       out  1  high in SETTLE/SAMPLE
//  done       out  1  high in DONE; held until next start or reset
//  pass       out  1  done && err_count==0; registered
//  err_count  out  3  number of vectors with >=1 mismatching gate (0..4)
//  fail_vec   out  4  sticky per-gate mismatch flags, bit i = dut_y[i] failed
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, vec=0, settle counter=0.
//   dut_a=dut_b=0, busy=done=pass=0, err_count=0, fail_vec=0.
//   Reset mid-run aborts immediately; no partial result is retained.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE   : start=1 -> SETTLE. On that edge: vec=0, counters cleared, err_count/fail_vec cleared.
//   SETTLE : counter counts 1..SETTLE_CYCLES. At the last count -> SAMPLE.
//   SAMPLE : exp = {~(a&b), a^b, a|b, a&b}; mis = dut_y ^ exp.
//            On this edge: fail_vec |= mis; err_count += (|mis).
//            If vec==3 -> DONE, else vec++ and -> SETTLE (counter reset).
//   DONE   : done=1; pass=(err_count==0).
//            start=1 -> behaves as from IDLE (restart clears all results, done/pass drop next cycle).
//  dut_a/dut_b are registered from vec and change on the same edge vec changes.
//   They are held stable through SETTLE and SAMPLE.
//  start while busy is ignored (no restart, no effect on counters).
//  dut_y is sampled only in SAMPLE; glitches during SETTLE are invisible.
//  Latency: each vector takes SETTLE_CYCLES+1 cycles.
//   done rises 4*(SETTLE_CYCLES+1) rising edges after the edge that sampled start (12 cycles at default).
//  err_count max 4 fits 3 bits; no saturation or wrap is needed.
//  vec is 2 bits; increment from 3 never occurs (DONE is taken first).
//  Outputs in DONE hold their values indefinitely until start or reset.
// TESTING
//  1 Ideal gate model on dut_y, start pulse -> done at edge 12; pass=1, err_count=0, fail_vec=4'b0000.
//  2 dut_y[1] stuck-at-0 -> err_count=3 (vectors 01,10,11), fail_vec=4'b0010, pass=0.
//  3 XOR output replaced by XNOR -> err_count=4, fail_vec=4'b0100, pass=0; dut_a/dut_b sequence 00,01,10,11, each held 3 cycles.
//  4 start re-pulsed at cycle 5 of a run -> ignored; done still at edge 12; results as for the unmodified run.
//  5 rst_n low at cycle 7 -> all outputs 0 asynchronously; new start after release -> full 12-cycle run, correct result.
//  6 SETTLE_CYCLES=1, ideal model -> done at edge 8, pass=1. start in DONE -> done/pass drop next cycle, new run passes.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Drives the four (a,b) input combinations 00,01,10,11 into a two-input gate
//   block, lets each vector settle, samples the AND/OR/XOR/NAND responses and
//   compares them against golden values. Reports sticky per-gate failures, a
//   per-vector mismatch count and pass/done status.
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   i_start      in   one-cycle pulse; starts a run from IDLE or DONE
//   o_dut_a      out  gate input a (vec[1]), registered
//   o_dut_b      out  gate input b (vec[0]), registered
//   i_dut_y      in   gate outputs [0]=AND [1]=OR [2]=XOR [3]=NAND
//   o_busy       out  high while settling/sampling
//   o_done       out  high in DONE until next start or reset
//   o_pass       out  done and no mismatching vector
//   o_err_count  out  number of vectors with at least one mismatching gate
//   o_fail_vec   out  sticky per-gate mismatch flags
module gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_dut_a,
    output logic       o_dut_b,
    input  logic [3:0] i_dut_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [2:0] o_err_count,
    output logic [3:0] o_fail_vec
);

    localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned ERR_W  = 3;
    localparam int unsigned GATE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VEC_W-1:0]    r_vec;
    logic [VEC_W-1:0]    w_vec_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [ERR_W-1:0]    r_err;
    logic [ERR_W-1:0]    w_err_nxt;
    logic [GATE_W-1:0]   r_fail;
    logic [GATE_W-1:0]   w_fail_nxt;
    logic [GATE_W-1:0]   w_exp;
    logic [GATE_W-1:0]   w_mis;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    // Golden response for the vector currently on the gate inputs
    assign w_exp = {~(r_vec[1] & r_vec[0]), r_vec[1] ^ r_vec[0],
                    r_vec[1] | r_vec[0],    r_vec[1] & r_vec[0]};
    assign w_mis = i_dut_y ^ w_exp;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
            r_busy  <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_pass  <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // Restart clears every result of the previous run
                if (i_start) begin
                    w_state_nxt = ST_SETTLE;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CNT_W'(SETTLE_CYCLES)) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_fail_nxt = r_fail | w_mis;
                w_err_nxt  = r_err + ERR_W'(|w_mis);
                w_cnt_nxt  = '0;
                if (r_vec == VEC_W'(3)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_vec_nxt   = r_vec + VEC_W'(1);
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_dut_a     = r_vec[1];
    assign o_dut_b     = r_vec[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (settle 2 and settle 1), a
// response model computed from elapsed cycles since start, a per-cycle compare
// process, and directed runs with hand-computed results.
module tb_gate_response_checker;

    localparam int S0 = 2;
    localparam int S1 = 1;

    // Golden responses per vector, {NAND,XOR,OR,AND}, from the gate truth tables
    localparam logic [3:0] GOLD [4] = '{4'b1000, 4'b1110, 4'b1110, 4'b0011};

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v;
    int         mode [2];
    logic [1:0] a, b, busy, done, pass;
    logic [2:0] err [2];
    logic [3:0] fv  [2];
    logic [3:0] y   [2];
    logic [3:0] glitch;

    int tests = 0;
    int fails = 0;

    bit m_ran  [2];
    int m_t    [2];
    int m_mode [2];

    always #5 clk = ~clk;

    gate_response_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start_v[0]),
        .o_dut_a(a[0]), .o_dut_b(b[0]), .i_dut_y(y[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_err_count(err[0]), .o_fail_vec(fv[0])
    );

    gate_response_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start_v[1]),
        .o_dut_a(a[1]), .o_dut_b(b[1]), .i_dut_y(y[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_err_count(err[1]), .o_fail_vec(fv[1])
    );

    function automatic int settle(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Gate block behaviour: 0 ideal, 1 OR stuck-at-0, 2 XNOR for XOR, 3 ideal but glitchy between samples
    function automatic logic [3:0] resp(int md, int v);
        logic [3:0] g;
        g = GOLD[v];
        if (md == 1) g = g & 4'b1101;
        if (md == 2) g = g ^ 4'b0100;
        return g;
    endfunction

    // True during the single cycle in which instance i must be sampling
    function automatic bit sampling_now(int i);
        int n;
        n = settle(i) + 1;
        return m_ran[i] && (m_t[i] < 4 * n) && (((m_t[i] + 1) % n) == 0);
    endfunction

    always @(negedge clk) glitch <= 4'($urandom);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            y[i] = resp(mode[i], int'({a[i], b[i]}));
            if (mode[i] == 3 && !sampling_now(i)) y[i] = glitch;
        end
    end

    // Model timeline: cycles elapsed since the accepted start edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ran[i] <= 1'b0;
                m_t[i]   <= 0;
                m_mode[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_v[i] && (!m_ran[i] || m_t[i] >= 4 * (settle(i) + 1))) begin
                    m_ran[i]  <= 1'b1;
                    m_t[i]    <= 0;
                    m_mode[i] <= mode[i];
                end else if (m_ran[i] && m_t[i] < 4 * (settle(i) + 1)) begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    function automatic exp_t expect_of(int i);
        exp_t       e;
        int         n, t, nsamp, vec, errs;
        logic [3:0] mis, acc;
        e = '0;
        if (!m_ran[i]) return e;
        n     = settle(i) + 1;
        t     = m_t[i];
        nsamp = (t < 4 * n) ? t / n : 4;
        vec   = (t < 4 * n) ? t / n : 3;
        errs  = 0;
        acc   = '0;
        for (int v = 0; v < nsamp; v++) begin
            mis = resp(m_mode[i], v) ^ GOLD[v];
            if (mis != 4'b0000) errs++;
            acc = acc | mis;
        end
        e.a    = 1'(vec >> 1);
        e.b    = 1'(vec & 1);
        e.busy = (t < 4 * n);
        e.done = !(t < 4 * n);
        e.pass = e.done && (errs == 0);
        e.err  = 3'(errs);
        e.fv   = acc;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = expect_of(i);
            chk($sformatf("i%0d_dut_a", i), int'(a[i]),    int'(e.a));
            chk($sformatf("i%0d_dut_b", i), int'(b[i]),    int'(e.b));
            chk($sformatf("i%0d_busy", i),  int'(busy[i]), int'(e.busy));
            chk($sformatf("i%0d_done", i),  int'(done[i]), int'(e.done));
            chk($sformatf("i%0d_pass", i),  int'(pass[i]), int'(e.pass));
            chk($sformatf("i%0d_err", i),   int'(err[i]),  int'(e.err));
            chk($sformatf("i%0d_fail_vec", i), int'(fv[i]), int'(e.fv));
        end
    end

    // Pulse start on instance i and count rising edges until done rises
    task automatic run(input int i, input int repulse, output int edges);
        @(posedge clk);
        #1 start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        chk($sformatf("i%0d_done_low_after_start", i), int'(done[i]), 0);
        edges = 0;
        while (!done[i] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            start_v[i] = (edges == repulse);
        end
        start_v[i] = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int i, input int p, input int e, input int f);
        chk({tag, "_pass"}, int'(pass[i]), p);
        chk({tag, "_err"},  int'(err[i]),  e);
        chk({tag, "_fv"},   int'(fv[i]),   f);
    endtask

    initial begin
        int edges;
        rst_n   = 1'b0;
        start_v = 2'b00;
        mode    = '{0, 0};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_done", int'(done[0]), 0);
        chk("reset_err",  int'(err[0]),  0);

        // Ideal gates
        run(0, -1, edges);
        chk("t1_done_edge", edges, 12);
        chk_result("t1", 0, 1, 0, 0);

        // OR stuck-at-0
        mode[0] = 1;
        run(0, -1, edges);
        chk("t2_done_edge", edges, 12);
        chk_result("t2", 0, 0, 3, 4'b0010);

        // XNOR in place of XOR
        mode[0] = 2;
        run(0, -1, edges);
        chk("t3_done_edge", edges, 12);
        chk_result("t3", 0, 0, 4, 4'b0100);

        // start re-pulsed while busy is ignored
        mode[0] = 0;
        run(0, 5, edges);
        chk("t4_done_edge", edges, 12);
        chk_result("t4", 0, 1, 0, 0);

        // Asynchronous reset mid-run, then a clean run
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", int'(busy[0]), 0);
        chk("t5_rst_a",    int'(a[0]),    0);
        chk("t5_rst_b",    int'(b[0]),    0);
        chk("t5_rst_err",  int'(err[0]),  0);
        chk("t5_rst_fv",   int'(fv[0]),   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(0, -1, edges);
        chk("t5_done_edge", edges, 12);
        chk_result("t5", 0, 1, 0, 0);

        // Responses glitch between samples but are correct when sampled
        mode[0] = 3;
        run(0, -1, edges);
        chk("tg_done_edge", edges, 12);
        chk_result("tg", 0, 1, 0, 0);
        mode[0] = 0;

        // Single-cycle settle, then restart straight from DONE
        run(1, -1, edges);
        chk("t6_done_edge", edges, 8);
        chk_result("t6a", 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        run(1, -1, edges);
        chk("t6_restart_done_edge", edges, 8);
        chk_result("t6b", 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
